sort_loader: RTL and testbench
==============================

Name: sort_loader

Overview:
- Upstream feeder for the compare-exchange sort network.
- Collects a serial stream of W-bit keys into one N-element parallel vector.
- Pads short frames with the maximum key, so pads sort to the high end.
- Presents the vector to the network with a valid/ready handshake and holds it until it is accepted.

Parameters:
- W, 3, key width in bits.
- N, 4, number of elements per vector (N >= 2).
- LW, $clog2(N+1), width of the length field (derived; do not override).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream key valid.
- in_ready  out  1  loader can accept a key this cycle.
- in_data  in  W  key.
- in_last  in  1  marks the final key of a frame; qualified by in_valid.
- vec_valid  out  1  vector complete and stable.
- vec_ready  in  1  downstream sort network accepts the vector.
- vec_data  out  N*W  element i at bits [i*W +: W]; element 0 is the first key received.
- vec_len  out  LW  number of real (non-pad) keys in the vector, 1..N.

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high, named reset.
- The state machine has two states, FILL and HOLD. The slot counter cnt is a register with range 0..N-1.
- Reset (sampled on a clk edge) sets:
  - state = FILL, cnt = 0
  - vec_data = 0, vec_len = 0, vec_valid = 0
  - reset has priority over every other input.
- in_ready = (state == FILL) && !reset. It is a combinational decode of state only, with no path from vec_ready.
- vec_valid = (state == HOLD), registered.
- Accept = in_valid && in_ready.
- FILL, on accept:
  - slot[cnt] <= in_data.
  - If cnt == N-1 or in_last:
    - all slots j > cnt <= all-ones (2^W - 1);
    - vec_len <= cnt + 1;
    - cnt <= 0;
    - state <= HOLD.
  - Else cnt <= cnt + 1.
- FILL, no accept: all registers hold.
- HOLD:
  - vec_data and vec_len are frozen; in_ready = 0.
  - When vec_valid && vec_ready, state <= FILL. The next key can be accepted on the following cycle.
- Latency: vec_valid rises 1 cycle after the accept of the last key of a frame.
- Minimum period: N+1 cycles per full vector.
- in_last on slot N-1 is identical to a natural completion.
- in_last on slot 0 gives vec_len = 1 and N-1 pad slots.
- Stale slots from the previous frame are always overwritten, either by keys or by pads, before vec_valid is asserted.
- vec_ready while in FILL is ignored.
- in_valid while in HOLD is not accepted. Upstream must hold the key stable until it is accepted.
- Reset in FILL mid-frame: the partial frame is discarded and cnt returns to 0.
- Reset in HOLD: vec_valid drops on the next edge and the vector is lost.
- A key of all-ones is legal and indistinguishable from a pad. vec_len is the authority on which slots are real.

Decomposition:
- Shared package sort_pkg holds:
  - localparams KEY_W = 3 and VEC_N = 4;
  - the state encoding (FILL = 1'b0, HOLD = 1'b1);
  - the function pad_key(W) returning all-ones.
- No sub-module is required; this is a single flat module.
- The network-side consumer is a separate sort_stage built from order instances, not part of this block.

Test Plan:
- Reset, then send keys 5, 1, 7, 2 with in_valid held and vec_ready = 0:
  - in_ready is high for 4 cycles;
  - vec_valid rises the cycle after key 2 is accepted;
  - vec_data = {2, 7, 1, 5} (element 3 .. 0), vec_len = 4;
  - in_ready = 0 while held.
- Short frame 3, 6 with in_last on key 6:
  - vec_data = {7, 7, 6, 3}, vec_len = 2.
- Single-key frame 4 with in_last:
  - vec_data = {7, 7, 7, 4}, vec_len = 1.
  - Send a following full frame 0, 0, 0, 0 and confirm no stale 4s remain.
- Back-pressure: hold vec_ready = 0 for 5 cycles while upstream drives in_valid = 1 with key 3:
  - vec_data is stable for all 5 cycles and key 3 is not consumed;
  - assert vec_ready: vec_valid falls next cycle and key 3 is accepted into slot 0 the cycle after.
- Reset mid-fill after keys 1, 2:
  - send 6, 5, 4, 3;
  - vec_data = {3, 4, 5, 6} and vec_len = 4, with no trace of keys 1 or 2.
- Random frames of length 1..4 with random in_valid / vec_ready gaps over 1000 frames:
  - a scoreboard checks vec_data, vec_len and padding;
  - checks that no key is ever lost or duplicated.

Source files
------------

// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared widths, FSM encoding and pad key for the sort network feeder
package sort_pkg;

  localparam int KEY_W = 3;
  localparam int VEC_N = 4;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  // All-ones key of width w; pads sort to the high end of the network.
  function automatic logic [31:0] pad_key(input int w);
    if (w >= 32) return '1;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/sort_loader.sv
// rtl/sort_loader.sv - gathers serial keys into one padded N-element vector for the sort network
module sort_loader
  import sort_pkg::*;
#(
  parameter int W = KEY_W,
  parameter int N = VEC_N,
  localparam int LW = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic           in_last,
  output logic           vec_valid,
  input  logic           vec_ready,
  output logic [N*W-1:0] vec_data,
  output logic [LW-1:0]  vec_len
);

  localparam int CW = $clog2(N);
  localparam logic [W-1:0] PAD = W'(pad_key(W));

  state_t        state;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          done;

  assign in_ready = (state == FILL) && !reset;
  assign accept   = in_valid && in_ready;
  assign done     = (cnt == CW'(N - 1)) || in_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FILL;
      cnt       <= '0;
      vec_data  <= '0;
      vec_len   <= '0;
      vec_valid <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            // Slots above the last key are padded in the same edge so no stale key survives.
            for (int j = 0; j < N; j++) begin
              if (CW'(j) == cnt)
                vec_data[j*W +: W] <= in_data;
              else if (done && (CW'(j) > cnt))
                vec_data[j*W +: W] <= PAD;
            end
            if (done) begin
              vec_len   <= LW'(cnt) + LW'(1);
              cnt       <= '0;
              state     <= HOLD;
              vec_valid <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        HOLD: begin
          if (vec_ready) begin
            state     <= FILL;
            vec_valid <= 1'b0;
          end
        end
        default: begin
          state     <= FILL;
          vec_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort_loader.sv
// tb/tb_sort_loader.sv - directed and randomized self-checking bench for sort_loader
module tb_sort_loader;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_data;
  logic        in_last;
  logic        vec_valid;
  logic        vec_ready;
  logic [11:0] vec_data;
  logic [2:0]  vec_len;

  int checks;
  int failures;
  int acc_keys;
  int acc_vecs;
  int sent_keys;
  int sent_vecs;

  sort_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .vec_data  (vec_data),
    .vec_len   (vec_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && in_valid && in_ready) acc_keys <= acc_keys + 1;
    if (!reset && vec_valid && vec_ready) acc_vecs <= acc_vecs + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_key(input logic [2:0] d, input logic l);
    int t;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    t = 0;
    while (!in_ready && t < 100) begin
      step();
      t++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_key_timeout in_ready=%b required=1", in_ready);
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_vec();
    int t;
    t = 0;
    while (vec_valid !== 1'b1 && t < 100) begin
      step();
      t++;
    end
    checks++;
    if (vec_valid !== 1'b1) begin
      failures++;
      $display("FAIL wait_vec_timeout vec_valid=%b required=1", vec_valid);
    end
  endtask

  task automatic drain();
    vec_ready = 1'b1;
    step();
    vec_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_ready got=%b want=0", in_ready);
    end
    checks++;
    if ({vec_valid, vec_data, vec_len} !== 16'h0) begin
      failures++;
      $display("FAIL reset_state valid=%b data=%h len=%0d want all zero", vec_valid, vec_data, vec_len);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_full_frame();
    logic [2:0] keys [4];
    keys = '{3'd5, 3'd1, 3'd7, 3'd2};
    in_valid = 1'b1;
    in_last  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = keys[i];
      checks++;
      if (in_ready !== 1'b1 || vec_valid !== 1'b0) begin
        failures++;
        $display("FAIL full_fill_cycle%0d in_ready=%b vec_valid=%b want 1/0", i, in_ready, vec_valid);
      end
      step();
    end
    checks++;
    if (vec_valid !== 1'b1) begin
      failures++;
      $display("FAIL full_latency vec_valid=%b want=1", vec_valid);
    end
    checks++;
    if (vec_data !== {3'd2, 3'd7, 3'd1, 3'd5} || vec_len !== 3'd4) begin
      failures++;
      $display("FAIL full_vector data=%h len=%0d want data=%h len=4", vec_data, vec_len, {3'd2, 3'd7, 3'd1, 3'd5});
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_hold_in_ready got=%b want=0", in_ready);
    end
    in_valid = 1'b0;
    drain();
    checks++;
    if (vec_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_release vec_valid=%b want=0", vec_valid);
    end
  endtask

  task automatic test_short_frame();
    send_key(3'd3, 1'b0);
    send_key(3'd6, 1'b1);
    wait_vec();
    checks++;
    if (vec_data !== {3'd7, 3'd7, 3'd6, 3'd3} || vec_len !== 3'd2) begin
      failures++;
      $display("FAIL short_vector data=%h len=%0d want data=%h len=2", vec_data, vec_len, {3'd7, 3'd7, 3'd6, 3'd3});
    end
    drain();
  endtask

  task automatic test_single_key();
    send_key(3'd4, 1'b1);
    wait_vec();
    checks++;
    if (vec_data !== {3'd7, 3'd7, 3'd7, 3'd4} || vec_len !== 3'd1) begin
      failures++;
      $display("FAIL single_vector data=%h len=%0d want data=%h len=1", vec_data, vec_len, {3'd7, 3'd7, 3'd7, 3'd4});
    end
    drain();
    for (int i = 0; i < 4; i++) send_key(3'd0, 1'b0);
    wait_vec();
    checks++;
    if (vec_data !== 12'h000 || vec_len !== 3'd4) begin
      failures++;
      $display("FAIL single_no_stale data=%h len=%0d want data=000 len=4", vec_data, vec_len);
    end
    drain();
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) send_key(3'(i + 1), 1'b0);
    wait_vec();
    in_valid = 1'b1;
    in_data  = 3'd3;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (vec_valid !== 1'b1 || in_ready !== 1'b0 || vec_data !== {3'd4, 3'd3, 3'd2, 3'd1} || vec_len !== 3'd4) begin
        failures++;
        $display("FAIL bp_hold_cycle%0d valid=%b in_ready=%b data=%h len=%0d want 1/0/%h/4",
                 i, vec_valid, in_ready, vec_data, vec_len, {3'd4, 3'd3, 3'd2, 3'd1});
      end
      step();
    end
    vec_ready = 1'b1;
    step();
    vec_ready = 1'b0;
    checks++;
    if (vec_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release valid=%b in_ready=%b want 0/1", vec_valid, in_ready);
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++;
    if (vec_valid !== 1'b1 || vec_data !== {3'd7, 3'd7, 3'd7, 3'd3} || vec_len !== 3'd1) begin
      failures++;
      $display("FAIL bp_key3_slot0 valid=%b data=%h len=%0d want 1/%h/1", vec_valid, vec_data, vec_len, {3'd7, 3'd7, 3'd7, 3'd3});
    end
    drain();
  endtask

  task automatic test_reset_midfill();
    send_key(3'd1, 1'b0);
    send_key(3'd2, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (vec_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midfill_reset valid=%b in_ready=%b want 0/1", vec_valid, in_ready);
    end
    send_key(3'd6, 1'b0);
    send_key(3'd5, 1'b0);
    send_key(3'd4, 1'b0);
    send_key(3'd3, 1'b0);
    wait_vec();
    checks++;
    if (vec_data !== {3'd3, 3'd4, 3'd5, 3'd6} || vec_len !== 3'd4) begin
      failures++;
      $display("FAIL midfill_vector data=%h len=%0d want data=%h len=4", vec_data, vec_len, {3'd3, 3'd4, 3'd5, 3'd6});
    end
    drain();
  endtask

  task automatic test_random();
    logic [2:0]  k [4];
    logic [11:0] exp_data;
    int          len;
    acc_keys  = 0;
    acc_vecs  = 0;
    sent_keys = 0;
    sent_vecs = 0;
    for (int f = 0; f < 1000; f++) begin
      len = $urandom_range(1, 4);
      exp_data = '1;
      for (int i = 0; i < 4; i++) begin
        k[i] = 3'($urandom_range(0, 7));
        if (i < len) exp_data[i*3 +: 3] = k[i];
      end
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) step();
        send_key(k[i], (i == len - 1) ? ((len < 4) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0);
      end
      sent_keys += len;
      wait_vec();
      repeat ($urandom_range(0, 3)) step();
      checks++;
      if (vec_data !== exp_data || vec_len !== 3'(len)) begin
        failures++;
        $display("FAIL rand_frame%0d data=%h len=%0d want data=%h len=%0d", f, vec_data, vec_len, exp_data, len);
      end
      drain();
      sent_vecs++;
    end
    step();
    checks++;
    if (acc_keys !== sent_keys || acc_vecs !== sent_vecs) begin
      failures++;
      $display("FAIL rand_counts keys=%0d vecs=%0d want keys=%0d vecs=%0d", acc_keys, acc_vecs, sent_keys, sent_vecs);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    acc_keys  = 0;
    acc_vecs  = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 3'd0;
    in_last   = 1'b0;
    vec_ready = 1'b0;
    test_reset();
    test_full_frame();
    test_short_frame();
    test_single_key();
    test_backpressure();
    test_reset_midfill();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
